md_issue_ctrl: RTL
==================

// Module: md_issue_ctrl
// PURPOSE
//  E-stage issue controller directly upstream of the multiply/divide unit.
//  Decodes the MDU-class op of the instruction in E and drives the MDU Start/MDUOp pair.
//  Tracks the multi-cycle busy window with its own counter.
//  Produces the D-stage stall for any MDU-class instruction that would collide with a pending or just-started operation.
// PARAMETERS
//  MUL_CYCLES  5  busy cycles after a mult/multu start cycle (1..15)
//  DIV_CYCLES  10 busy cycles after a div/divu start cycle (1..15)
//  OP_W        4  width of MDU op code
// PORTS
//  clk          in   1     clock, all state on posedge
//  reset        in   1     synchronous, active-high
//  e_valid_i    in   1     instruction in E is valid (not a bubble)
//  e_op_i       in   OP_W  MDU op of E instr: 0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi,8 mtlo,9 madd
//  d_md_i       in   1     instruction in D is MDU-class (op 1..9)
//  mdu_start_o  out  1     Start to MDU (combinational)
//  mdu_op_o     out  OP_W  MDUOp to MDU (combinational)
//  busy_o       out  1     operation in flight (registered count != 0)
//  stall_o      out  1     freeze PC/D, bubble into E
//  cnt_o        out  4     remaining busy cycles (debug/verification)
//  ovl_err_o    out  1     sticky: MDU op presented in E while busy
// BEHAVIOUR
//  States: IDLE, MUL, DIV. Counter cnt[3:0]. busy_o = (state!=IDLE).
//  Reset values:
//   - state=IDLE, cnt=0, ovl_err_o=0.
//   - With e_valid_i=0: mdu_start_o=0, mdu_op_o=0, stall_o=0.
//  Start decode:
//   - issue = e_valid_i && (e_op_i in 1..4) && state==IDLE.
//   - mdu_start_o = issue.
//   - mdu_op_o = e_op_i when e_valid_i && state==IDLE, else 0.
//   - mf/mt/madd (5..9) pass through with mdu_start_o=0.
//  Transitions:
//   - IDLE --issue mult/multu--> MUL, cnt<=MUL_CYCLES.
//   - IDLE --issue div/divu--> DIV, cnt<=DIV_CYCLES.
//   - MUL/DIV: cnt<=cnt-1 each cycle; when cnt==1 -> IDLE, cnt<=0.
//  Timing: start at edge-cycle t gives busy_o=1 for cycles t+1..t+N; IDLE at t+N+1.
//   - A new op can issue at t+N+1.
//  Stall:
//   - stall_o = d_md_i && (mdu_start_o || busy_o).
//   - This covers the start cycle, where the MDU's own Busy is still low.
//  Overlap:
//   - Condition: e_valid_i && e_op_i!=0 while busy_o=1 (cannot occur with a correct stall).
//   - Required response: mdu_op_o=0, no start, state/cnt unaffected, ovl_err_o<=1.
//   - ovl_err_o clears only on reset.
//  Invalid codes: e_op_i 10..15 treated as 0 (none) in all logic.
//  Reset mid-operation: reset wins over all; next cycle IDLE, cnt=0, busy_o=0, ovl_err_o=0.
//  No flush input. An issued op always runs its full count.
// TESTING
//  1. Reset, idle, d_md_i=1, e_op_i=0 -> stall_o=0, busy_o=0, cnt_o=0.
//  2. e_op_i=1 valid at t -> start=1 at t; busy_o=1 t+1..t+5; cnt_o 5,4,3,2,1; IDLE at t+6.
//  3. e_op_i=3 at t with d_md_i=1 held -> stall_o=1 from t through t+10; stall_o=0 at t+11.
//  4. e_op_i=6 (mflo) while idle -> mdu_op_o=6, start=0, busy_o stays 0.
//  5. mult at t, e_op_i=2 injected at t+2 -> no start, mdu_op_o=0, ovl_err_o=1 sticky; busy still ends t+6.
//  6. div at t, reset at t+4 -> t+5: busy_o=0, cnt_o=0; new divu at t+5 starts, cnt_o=10 at t+6.

Source files
------------

// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the multiply/divide unit: decodes the MDU op,
// issues Start/MDUOp, tracks the busy window and raises the D-stage stall.
module md_issue_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10,
  parameter int unsigned OP_W       = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            e_valid_i,
  input  logic [OP_W-1:0] e_op_i,
  input  logic            d_md_i,
  output logic            mdu_start_o,
  output logic [OP_W-1:0] mdu_op_o,
  output logic            busy_o,
  output logic            stall_o,
  output logic [3:0]      cnt_o,
  output logic            ovl_err_o
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [OP_W-1:0]  op_eff;
  logic             is_mul;
  logic             is_div;
  logic             idle;
  logic             issue;
  logic             overlap;

  // Codes above madd are treated as "no op" everywhere.
  assign op_eff  = (e_op_i <= OP_W'(9)) ? e_op_i : '0;
  assign is_mul  = (op_eff == OP_W'(1)) || (op_eff == OP_W'(2));
  assign is_div  = (op_eff == OP_W'(3)) || (op_eff == OP_W'(4));
  assign idle    = (state == IDLE);
  assign issue   = e_valid_i && (is_mul || is_div) && idle;
  assign overlap = e_valid_i && (op_eff != '0) && !idle;

  assign mdu_start_o = issue;
  assign mdu_op_o    = (e_valid_i && idle) ? op_eff : '0;
  assign busy_o      = !idle;
  // Start cycle is included because the MDU's own busy is not yet up.
  assign stall_o     = d_md_i && (mdu_start_o || busy_o);
  assign cnt_o       = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ovl_err_o <= 1'b0;
    end else begin
      if (overlap) begin
        ovl_err_o <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (issue && is_mul) begin
            state <= MUL;
            cnt   <= CNT_W'(MUL_CYCLES);
          end else if (issue && is_div) begin
            state <= DIV;
            cnt   <= CNT_W'(DIV_CYCLES);
          end
        end
        MUL, DIV: begin
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
